// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU glue: FSM state encodings and the ALU opcode set.
package uart_alu_pkg;

    localparam logic [2:0] S_WAIT_A   = 3'd0;
    localparam logic [2:0] S_WAIT_B   = 3'd1;
    localparam logic [2:0] S_WAIT_OP  = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_TX_START = 3'd4;
    localparam logic [2:0] S_TX_WAIT  = 3'd5;

    // Opcodes understood by the ALU sitting next to this interface.
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_iface_timeout.sv
// Inter-byte timeout counter: cleared by i_clear, counts while i_enable, flags the last cycle.
// Only instantiated when UART_IFACE_TIMEOUT_EN is defined.
module uart_iface_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;
    logic          w_expire;

    assign w_expire = i_enable && (r_count == LAST);
    assign o_expire = w_expire;

    // Held at zero whenever the FSM is not waiting for a follow-on byte.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from UART RX, latches the ALU result and hands it to UART TX.
// Optional inter-byte timeout enabled by defining UART_IFACE_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic             i_tx_done,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_op,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy
);

    logic [2:0]       r_state;
    logic [DBIT-1:0]  r_data_a;
    logic [DBIT-1:0]  r_data_b;
    logic [NB_OP-1:0] r_op;
    logic             r_tx_start;
    logic [DBIT-1:0]  r_tx_data;
    logic             r_busy;
    logic             w_timeout;

`ifdef UART_IFACE_TIMEOUT_EN
    logic w_cnt_en;

    assign w_cnt_en = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

    uart_iface_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (i_rx_done),
        .i_enable (w_cnt_en),
        .o_expire (w_timeout)
    );
`else
    // No timeout hardware: constant false for any legal TIMEOUT_CYC.
    assign w_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_WAIT_A;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_WAIT_A: begin
                    if (i_rx_done) begin
                        r_data_a <= i_rx_data;
                        r_state  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (i_rx_done) begin
                        r_data_b <= i_rx_data;
                        r_state  <= S_WAIT_OP;
                    end else if (w_timeout) begin
                        r_state  <= S_WAIT_A;
                    end
                end
                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        r_op    <= i_rx_data[NB_OP-1:0];
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (w_timeout) begin
                        r_state <= S_WAIT_A;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle; the ALU output is settled.
                    r_tx_data  <= i_alu_result;
                    r_tx_start <= 1'b1;
                    r_state    <= S_TX_START;
                end
                S_TX_START: begin
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT_A;
                    end
                end
                default: begin
                    r_state <= S_WAIT_A;
                end
            endcase
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_op       = r_op;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;

endmodule
